// File: rtl/custom_axi_ip_pkg.sv
// custom_axi_ip_pkg: core status encoding, register map offsets, bit positions and AXI response codes
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } status_e;

    // word offsets, decoded from addr[3:2]
    localparam logic [1:0] CTRL_OFF    = 2'd0;
    localparam logic [1:0] DATA_IN_OFF = 2'd1;
    localparam logic [1:0] STATUS_OFF  = 2'd2;
    localparam logic [1:0] RESULT_OFF  = 2'd3;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_DONE_BIT   = 2;
    localparam int STAT_REJECT_BIT = 3;
    localparam int STAT_ERR_BIT    = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/custom_axi_ip_regs.sv
// custom_axi_ip_regs: AXI4-Lite register block that starts the custom core, tracks its status and latches its result
module custom_axi_ip_regs
    import custom_axi_ip_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic [31:0]             hw_data_o,
    output logic                    hw_enable_o,
    input  logic [31:0]             hw_data_i,
    input  status_e                 hw_status_i,
    output logic                    irq_o
);

    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
    logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
    logic                    arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, rd_word;
    logic [31:0]             data_in_q, data_in_d, result_q, result_d;
    logic                    irq_en_q, irq_en_d, done_q, done_d, reject_q, reject_d;
    logic                    err_q, err_d, enable_q, enable_d, irq_q, irq_d;
    status_e                 prev_status_q;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit, wr_ok, rd_ok;
    logic                    wr_ctrl, wr_data_in, wr_status, start_req, w1c_en, done_set, err_set;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{aw_addr_q[1:0], s_axil_araddr[1:0]};

    always_comb begin
        aw_hs      = s_axil_awvalid && awready_q;
        w_hs       = s_axil_wvalid && wready_q;
        b_hs       = bvalid_q && s_axil_bready;
        ar_hs      = s_axil_arvalid && arready_q;
        r_hs       = rvalid_q && s_axil_rready;
        wr_commit  = aw_held_q && w_held_q && !bvalid_q;
        wr_ok      = (aw_addr_q >> 4) == '0;
        rd_ok      = (s_axil_araddr >> 4) == '0;
        wr_ctrl    = wr_commit && wr_ok && aw_addr_q[3:2] == CTRL_OFF;
        wr_data_in = wr_commit && wr_ok && aw_addr_q[3:2] == DATA_IN_OFF;
        wr_status  = wr_commit && wr_ok && aw_addr_q[3:2] == STATUS_OFF;
        start_req  = wr_ctrl && w_strb_q[0] && w_data_q[CTRL_START_BIT];
        w1c_en     = wr_status && w_strb_q[0];
        done_set   = prev_status_q == ST_DONE && hw_status_i != ST_DONE;
        err_set    = hw_status_i == ST_ERROR && prev_status_q != ST_ERROR;
        aw_held_d  = b_hs ? 1'b0 : aw_hs ? 1'b1 : aw_held_q;
        aw_addr_d  = aw_hs ? s_axil_awaddr : aw_addr_q;
        w_held_d   = b_hs ? 1'b0 : w_hs ? 1'b1 : w_held_q;
        w_data_d   = w_hs ? s_axil_wdata : w_data_q;
        w_strb_d   = w_hs ? s_axil_wstrb : w_strb_q;
        bvalid_d   = wr_commit ? 1'b1 : b_hs ? 1'b0 : bvalid_q;
        bresp_d    = wr_commit ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : bresp_q;
        // readies are registered so they sit low throughout reset
        awready_d  = !aw_held_d && !bvalid_d;
        wready_d   = !w_held_d && !bvalid_d;
        rvalid_d   = ar_hs ? 1'b1 : r_hs ? 1'b0 : rvalid_q;
        arready_d  = !rvalid_d;
        rd_word    = s_axil_araddr[3:2] == CTRL_OFF    ? {{(DATA_WIDTH-2){1'b0}}, irq_en_q, 1'b0} :
                     s_axil_araddr[3:2] == DATA_IN_OFF ? data_in_q :
                     s_axil_araddr[3:2] == STATUS_OFF  ? {{(DATA_WIDTH-5){1'b0}}, err_q, reject_q, done_q, hw_status_i} :
                                                         result_q;
        rdata_d    = ar_hs ? (rd_ok ? rd_word : '0) : rdata_q;
        rresp_d    = ar_hs ? (rd_ok ? RESP_OKAY : RESP_SLVERR) : rresp_q;
        data_in_d  = data_in_q;
        for (int b = 0; b < DATA_WIDTH/8; b++)
            data_in_d[8*b +: 8] = wr_data_in && w_strb_q[b] ? w_data_q[8*b +: 8] : data_in_q[8*b +: 8];
        irq_en_d   = wr_ctrl && w_strb_q[0] ? w_data_q[CTRL_IRQ_EN_BIT] : irq_en_q;
        enable_d   = start_req && hw_status_i == ST_IDLE;
        // hardware set takes priority over a simultaneous software clear
        reject_d   = (start_req && hw_status_i != ST_IDLE) || (reject_q && !(w1c_en && w_data_q[STAT_REJECT_BIT]));
        done_d     = done_set || (done_q && !(w1c_en && w_data_q[STAT_DONE_BIT]));
        err_d      = err_set || (err_q && !(w1c_en && w_data_q[STAT_ERR_BIT]));
        result_d   = done_set ? hw_data_i : result_q;
        irq_d      = irq_en_q && (done_q || err_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held_q     <= 1'b0;
            aw_addr_q     <= '0;
            w_held_q      <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            data_in_q     <= '0;
            result_q      <= '0;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            reject_q      <= 1'b0;
            err_q         <= 1'b0;
            enable_q      <= 1'b0;
            irq_q         <= 1'b0;
            prev_status_q <= ST_IDLE;
        end else begin
            aw_held_q     <= aw_held_d;
            aw_addr_q     <= aw_addr_d;
            w_held_q      <= w_held_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            data_in_q     <= data_in_d;
            result_q      <= result_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            reject_q      <= reject_d;
            err_q         <= err_d;
            enable_q      <= enable_d;
            irq_q         <= irq_d;
            prev_status_q <= hw_status_i;
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign hw_data_o      = data_in_q;
    assign hw_enable_o    = enable_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// tb_custom_axi_ip_regs: directed and randomized AXI4-Lite traffic checked against a register-level model
module tb_custom_axi_ip_regs;
    import custom_axi_ip_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  s_axil_awaddr = '0, s_axil_araddr = '0;
    logic        s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_bready = 1'b0;
    logic        s_axil_arvalid = 1'b0, s_axil_rready = 1'b0;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic [31:0] s_axil_rdata, hw_data_o;
    logic        hw_enable_o, irq_o;
    logic [31:0] hw_data_i = '0;
    status_e     hw_status_i = ST_IDLE;

    custom_axi_ip_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .hw_data_o(hw_data_o), .hw_enable_o(hw_enable_o), .hw_data_i(hw_data_i),
        .hw_status_i(hw_status_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0, en_cnt = 0, exp_en = 0, b_rise = 0, wr_cnt = 0;
    logic bv_prev = 1'b0;
    logic [31:0] m_data_in, m_result;
    logic m_irq_en, m_done, m_reject, m_err;
    status_e m_status = ST_IDLE;

    always @(negedge clk_i) begin
        if (hw_enable_o) en_cnt++;
        if (s_axil_bvalid && !bv_prev) b_rise++;
        bv_prev = s_axil_bvalid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data_in = '0;
        m_result  = '0;
        m_irq_en  = 1'b0;
        m_done    = 1'b0;
        m_reject  = 1'b0;
        m_err     = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {30'b0, m_irq_en, 1'b0};
            2'd1:    return m_data_in;
            2'd2:    return {27'b0, m_err, m_reject, m_done, m_status};
            default: return m_result;
        endcase
    endfunction

    task automatic model_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        case (a[3:2])
            2'd0: if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) begin
                    if (m_status == ST_IDLE) exp_en++;
                    else m_reject = 1'b1;
                end
            end
            2'd1: for (int i = 0; i < 4; i++) if (s[i]) m_data_in[8*i +: 8] = d[8*i +: 8];
            2'd2: if (s[0]) begin
                if (d[2]) m_done = 1'b0;
                if (d[3]) m_reject = 1'b0;
                if (d[4]) m_err = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int bd);
        logic [1:0] resp;
        int n;
        fork
            begin
                int k;
                k = 0;
                repeat (awd + 1) @(negedge clk_i);
                s_axil_awaddr = a;
                s_axil_awvalid = 1'b1;
                while (!s_axil_awready && k < 40) begin @(negedge clk_i); k++; end
                if (k == 40) chk("aw_timeout", 0, 1);
                @(negedge clk_i);
                s_axil_awvalid = 1'b0;
            end
            begin
                int k;
                k = 0;
                repeat (wd + 1) @(negedge clk_i);
                s_axil_wdata = d;
                s_axil_wstrb = s;
                s_axil_wvalid = 1'b1;
                while (!s_axil_wready && k < 40) begin @(negedge clk_i); k++; end
                if (k == 40) chk("w_timeout", 0, 1);
                @(negedge clk_i);
                s_axil_wvalid = 1'b0;
            end
        join
        n = 0;
        while (!s_axil_bvalid && n < 40) begin @(negedge clk_i); n++; end
        chk("b_valid", s_axil_bvalid, 1);
        resp = s_axil_bresp;
        repeat (bd) begin
            @(negedge clk_i);
            chk("b_hold", {s_axil_bvalid, s_axil_awready, s_axil_wready, s_axil_bresp}, {1'b1, 1'b0, 1'b0, resp});
        end
        chk("bresp", resp, RESP_OKAY);
        s_axil_bready = 1'b1;
        @(negedge clk_i);
        s_axil_bready = 1'b0;
        wr_cnt++;
        chk("b_clr", s_axil_bvalid, 0);
        chk("b_once", b_rise, wr_cnt);
    endtask

    task automatic axi_rd(input logic [3:0] a, input int rd_dly, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge clk_i);
        s_axil_araddr = a;
        s_axil_arvalid = 1'b1;
        while (!s_axil_arready && n < 40) begin @(negedge clk_i); n++; end
        if (n == 40) chk("ar_timeout", 0, 1);
        @(negedge clk_i);
        s_axil_arvalid = 1'b0;
        chk("r_valid", s_axil_rvalid, 1);
        d = s_axil_rdata;
        resp = s_axil_rresp;
        repeat (rd_dly) begin
            @(negedge clk_i);
            chk("r_hold", {s_axil_rvalid, s_axil_arready, s_axil_rresp, s_axil_rdata}, {1'b1, 1'b0, resp, d});
        end
        s_axil_rready = 1'b1;
        @(negedge clk_i);
        s_axil_rready = 1'b0;
        chk("r_clr", s_axil_rvalid, 0);
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int awd, input int wd, input int bd);
        axi_wr(a, d, s, awd, wd, bd);
        model_wr(a, d, s);
        chk("enable_cnt", en_cnt, exp_en);
        @(negedge clk_i);
        chk("irq", irq_o, m_irq_en & (m_done | m_err));
    endtask

    task automatic do_rd(input logic [3:0] a, input int rd_dly, output logic [31:0] d);
        logic [1:0] r;
        axi_rd(a, rd_dly, d, r);
        chk("rdata", d, model_rd(a));
        chk("rresp", r, RESP_OKAY);
    endtask

    task automatic set_status(input status_e st, input logic [31:0] d);
        @(negedge clk_i);
        if (m_status == ST_DONE && st != ST_DONE) begin
            m_done = 1'b1;
            m_result = d;
        end
        if (st == ST_ERROR && m_status != ST_ERROR) m_err = 1'b1;
        m_status = st;
        hw_status_i = st;
        hw_data_i = d;
        repeat (2) @(negedge clk_i);
        chk("irq", irq_o, m_irq_en & (m_done | m_err));
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        int op, en0, b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_flags", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, s_axil_arready,
                          s_axil_rvalid, s_axil_rresp, hw_enable_o, irq_o}, 0);
        chk("rst_hw_data", hw_data_o, 0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        for (int a = 0; a < 4; a++) begin
            axi_rd(4'(a * 4), 0, rd, rr);
            chk("rst_reg", rd, 0);
            chk("rst_rresp", rr, RESP_OKAY);
        end
        // AW ahead of W, then W ahead of AW with partial strobes
        do_wr(4'h4, 32'hDEADBEEF, 4'hF, 0, 3, 0);
        do_wr(4'h4, 32'h0000_1234, 4'b0011, 3, 0, 0);
        do_rd(4'h4, 0, rd);
        chk("data_in_merge", rd, 32'hDEAD1234);
        // start while idle, then walk the core through BUSY -> DONE -> IDLE
        do_wr(4'h4, 32'h10, 4'hF, 0, 0, 0);
        en0 = en_cnt;
        do_wr(4'h0, 32'h3, 4'h1, 1, 0, 0);
        chk("start_pulse", en_cnt - en0, 1);
        chk("hw_data_o", hw_data_o, 32'h10);
        set_status(ST_BUSY, 32'h0);
        set_status(ST_DONE, 32'h11);
        set_status(ST_IDLE, 32'h11);
        do_rd(4'hC, 0, rd);
        chk("result", rd, 32'h11);
        do_rd(4'h8, 0, rd);
        chk("done_sticky", rd[2], 1);
        chk("irq_done", irq_o, 1);
        // start while busy is rejected, then W1C clears the reject flag
        set_status(ST_BUSY, 32'h11);
        en0 = en_cnt;
        do_wr(4'h0, 32'h1, 4'h1, 0, 2, 1);
        chk("no_pulse_busy", en_cnt - en0, 0);
        do_rd(4'h8, 0, rd);
        chk("reject_set", rd[3], 1);
        do_wr(4'h8, 32'h8, 4'h1, 0, 0, 0);
        do_rd(4'h8, 0, rd);
        chk("reject_clr", rd[3], 0);
        // done sets in the same cycle its W1C commits
        do_wr(4'h0, 32'h2, 4'h1, 0, 0, 0);
        do_wr(4'h8, 32'h4, 4'h1, 0, 0, 0);
        set_status(ST_DONE, 32'h22);
        fork
            axi_wr(4'h8, 32'h4, 4'h1, 0, 0, 0);
            begin
                @(negedge clk_i);
                @(negedge clk_i);
                hw_status_i = ST_IDLE;
            end
        join
        m_status = ST_IDLE;
        m_done = 1'b1;
        m_result = 32'h22;
        @(negedge clk_i);
        do_rd(4'h8, 0, rd);
        chk("set_wins", rd[2], 1);
        chk("irq_kept", irq_o, 1);
        // long back-pressure on both channels, read and write overlapping
        fork
            axi_wr(4'h4, 32'h5555AAAA, 4'hF, 0, 0, 5);
            axi_rd(4'hC, 5, rd, rr);
        join
        model_wr(4'h4, 32'h5555AAAA, 4'hF);
        chk("overlap_rd", rd, 32'h22);
        do_rd(4'h4, 5, rd);
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 5);
            if (op < 4)
                do_wr(4'(op * 4), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else if (op == 4)
                do_rd(4'($urandom_range(0, 3) * 4), $urandom_range(0, 2), rd);
            else
                set_status(status_e'($urandom_range(0, 3)), $urandom);
        end
        // reset between address/data acceptance and commit
        set_status(ST_IDLE, 32'h0);
        do_wr(4'h4, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        en0 = en_cnt;
        b0 = b_rise;
        @(negedge clk_i);
        s_axil_awaddr = 4'h0;
        s_axil_wdata = 32'h1;
        s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid = 1'b1;
        @(negedge clk_i);
        s_axil_awvalid = 1'b0;
        s_axil_wvalid = 1'b0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_no_bvalid", b_rise - b0, 0);
        chk("rst_no_pulse", en_cnt - en0, 0);
        chk("rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
        model_reset();
        do_rd(4'h4, 0, rd);
        do_rd(4'h0, 0, rd);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/custom_axi_ip_regs.md
Name: custom_axi_ip_regs

Overview:
AXI4-Lite subordinate register block that drives the register-to-hardware interface of the custom AXI IP core. Software writes an input operand and a start command. The block pulses the enable into the core, tracks the core's status_e, captures the result and raises a sticky done interrupt. It sits between the SoC AXI4-Lite interconnect and the core.

Parameters:
ADDR_WIDTH, 4, AXI4-Lite address width; register offsets decoded on addr[3:2], addr[1:0] ignored
DATA_WIDTH, 32, AXI4-Lite data width; only 32 supported

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
s_axil_awaddr  input  ADDR_WIDTH  write address
s_axil_awvalid  input  1  write address valid
s_axil_awready  output  1  write address ready
s_axil_wdata  input  DATA_WIDTH  write data
s_axil_wstrb  input  DATA_WIDTH/8  write byte strobes
s_axil_wvalid  input  1  write data valid
s_axil_wready  output  1  write data ready
s_axil_bresp  output  2  write response
s_axil_bvalid  output  1  write response valid
s_axil_bready  input  1  write response ready
s_axil_araddr  input  ADDR_WIDTH  read address
s_axil_arvalid  input  1  read address valid
s_axil_arready  output  1  read address ready
s_axil_rdata  output  DATA_WIDTH  read data
s_axil_rresp  output  2  read response
s_axil_rvalid  output  1  read data valid
s_axil_rready  input  1  read data ready
hw_data_o  output  32  operand to core (DATA_IN register)
hw_enable_o  output  1  one-cycle start pulse to core
hw_data_i  input  32  result from core
hw_status_i  input  status_e  core state (IDLE/BUSY/DONE/ERROR)
irq_o  output  1  level interrupt

Behaviour:
- One clock (clk_i); reset asynchronous, active-low (rst_ni). All registers, outputs and handshake flags reset to 0, including ready/valid, bresp/rresp, hw_data_o, hw_enable_o and irq_o.
- Register map:
  - 0x0 CTRL: bit0 START (write-1 pulses hw_enable_o, reads 0); bit1 IRQ_EN (RW).
  - 0x4 DATA_IN: RW, drives hw_data_o.
  - 0x8 STATUS: [1:0] live hw_status_i (RO); bit2 DONE_STICKY (W1C); bit3 REJECT_STICKY (W1C); bit4 ERR_STICKY (W1C).
  - 0xC RESULT: RO.
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle, and each is latched.
  - awready is high while no AW is latched and bvalid is low. wready follows the same rule for W.
  - When both AW and W are held, the write commits in that cycle. bvalid rises the next cycle and holds until bready, then the latches clear.
  - One outstanding write at a time.
- Byte strobes: wstrb applies per byte to DATA_IN and CTRL. START and IRQ_EN take effect only if wstrb[0] is set. W1C bits clear only if wstrb[0] is set.
- Read channel:
  - arready is high while rvalid is low.
  - After the AR handshake, rdata and rresp are registered and rvalid rises the next cycle. rdata holds stable until rready.
- Unmapped addresses: none exist with ADDR_WIDTH=4. For ADDR_WIDTH>4, any nonzero addr above bit 3 returns SLVERR (2'b10), the write is ignored and the read returns 0. Otherwise the response is OKAY (2'b00).
- START:
  - If hw_status_i==IDLE at commit, hw_enable_o is high for exactly the next cycle, one-cycle latency from commit.
  - Otherwise no pulse, REJECT_STICKY is set, and bresp is still OKAY.
  - A DATA_IN write and a START write are separate transactions. hw_data_o is stable before the pulse.
- Completion tracking (registered prev_status):
  - When prev_status==DONE and hw_status_i!=DONE, RESULT captures hw_data_i and DONE_STICKY is set.
  - On any entry into ERROR, ERR_STICKY is set and RESULT is unchanged.
- Simultaneous events:
  - A hardware set and a W1C on the same bit in the same cycle: set wins.
  - A read of STATUS in the W1C commit cycle returns the pre-clear value.
  - A read and a write in the same cycle proceed independently.
- irq_o = IRQ_EN & (DONE_STICKY | ERR_STICKY), registered (one cycle after the sticky bit sets).
- Reset mid-transaction: all pending handshakes are dropped, no bvalid/rvalid is issued, and no enable pulse occurs.

Decomposition:
- custom_axi_ip_pkg: reuse status_e. Add register offset localparams (CTRL_OFF, DATA_IN_OFF, STATUS_OFF, RESULT_OFF), bit-index constants, and the AXI response codes RESP_OKAY and RESP_SLVERR.
- No sub-module. Write channel, read channel and register file stay in one module.

Test Plan:
- Reset, then read all 4 registers -> every register reads 0x0, all with rresp OKAY.
- AW issued 3 cycles before W, writing DATA_IN=0xDEADBEEF; then a W-before-AW write with wstrb=4'b0011 and data 0x0000_1234 -> DATA_IN reads 0xDEAD1234, and exactly one bvalid occurs per write.
- With DATA_IN=0x10, write CTRL=0x3 while the model core is IDLE -> hw_enable_o is high for one cycle; core goes BUSY, then DONE, then IDLE with hw_data_i=0x11; RESULT reads 0x11; STATUS bit2=1; irq_o=1.
- Write CTRL=0x1 while hw_status_i=BUSY -> no hw_enable_o pulse; STATUS bit3=1; writing STATUS=0x8 clears it.
- DONE_STICKY set in the same cycle as a W1C write of 0x4 -> bit2 remains 1; irq_o stays high.
- Hold bready and rready low for 5 cycles -> bvalid/rvalid and rdata stay stable; awready and arready stay low until the handshake completes.
